fp16_accumulator: RTL and testbench

FP16_ACCUMULATOR -- requirements
Module: fp16_accumulator

---
 rtl/fp16_accumulator.sv | 227 ++++++++++++++++++++++
 tb/tb_fp16_accumulator.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fp16_accumulator.sv
// Binary16 accumulator: each accepted addend is summed into the running total
// through a four-state ALIGN/ADD/NORM sequence with truncating rounding.
module fp16_accumulator (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [15:0] in_data,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        clear,
    output logic [15:0] acc_out,
    output logic        out_valid
);
    localparam int                DATA_W = 16;
    localparam logic [DATA_W-1:0] QNAN   = 16'h7E00;

    typedef enum logic [1:0] {IDLE, ALIGN, ADD, NORM} state_t;

    state_t            r_state;
    logic              r_in_ready;
    logic              r_out_valid;
    logic [DATA_W-1:0] r_acc;

    logic [DATA_W-1:0] r_opa_p0;
    logic [DATA_W-1:0] r_opb_p0;

    logic [10:0]       r_sig_l_p1;
    logic [10:0]       r_sig_s_p1;
    logic [4:0]        r_exp_p1;
    logic              r_sign_p1;
    logic              r_sub_p1;
    logic              r_zsign_p1;
    logic              r_spec_p1;
    logic [DATA_W-1:0] r_spec_val_p1;

    logic [11:0]       r_sum_p2;
    logic [4:0]        r_exp_p2;
    logic              r_sign_p2;
    logic              r_zsign_p2;
    logic              r_spec_p2;
    logic [DATA_W-1:0] r_spec_val_p2;

    logic              w_sa;
    logic              w_sb;
    logic [4:0]        w_ea;
    logic [4:0]        w_eb;
    logic [9:0]        w_ma;
    logic [9:0]        w_mb;
    logic              w_nan_a;
    logic              w_nan_b;
    logic              w_inf_a;
    logic              w_inf_b;
    logic [10:0]       w_sig_a;
    logic [10:0]       w_sig_b;
    logic              w_a_big;
    logic [4:0]        w_e_l;
    logic [4:0]        w_e_s;
    logic [10:0]       w_sig_l;
    logic [10:0]       w_sig_s;
    logic              w_sign_l;
    logic [4:0]        w_diff;
    logic [10:0]       w_sig_s_sh;
    logic              w_spec;
    logic [DATA_W-1:0] w_spec_val;
    logic [11:0]       w_sum;

    // Leading-one normalisation, truncation toward zero, flush of tiny results
    // to +0 and saturation of oversized results to a signed infinity.
    function automatic logic [DATA_W-1:0] f_norm_trunc(
        input logic [11:0] sum,
        input logic [4:0]  exp,
        input logic        sign,
        input logic        zsign
    );
        logic signed [6:0] e;
        logic [9:0]        mant;
        logic [3:0]        lz;
        f_norm_trunc = {zsign, 15'd0};
        if (sum != 12'd0) begin
            if (sum[11]) begin
                e    = $signed({2'b00, exp}) + 7'sd1;
                mant = sum[10:1];
            end else begin
                lz = 4'd0;
                for (int i = 0; i <= 10; i++) begin
                    if (sum[i]) lz = 4'(10 - i);
                end
                e    = $signed({2'b00, exp}) - $signed({3'b000, lz});
                mant = 10'(sum[10:0] << lz);
            end
            if (e <= 7'sd0)
                f_norm_trunc = 16'h0000;
            else if (e >= 7'sd31)
                f_norm_trunc = {sign, 5'h1F, 10'd0};
            else
                f_norm_trunc = {sign, e[4:0], mant};
        end
    endfunction

    always_comb begin
        w_sa    = r_opa_p0[15];
        w_sb    = r_opb_p0[15];
        w_ea    = r_opa_p0[14:10];
        w_eb    = r_opb_p0[14:10];
        w_ma    = r_opa_p0[9:0];
        w_mb    = r_opb_p0[9:0];
        w_nan_a = (w_ea == 5'd31) && (w_ma != 10'd0);
        w_nan_b = (w_eb == 5'd31) && (w_mb != 10'd0);
        w_inf_a = (w_ea == 5'd31) && (w_ma == 10'd0);
        w_inf_b = (w_eb == 5'd31) && (w_mb == 10'd0);
        // exp=0 covers both zero and subnormal: both behave as a signed zero
        w_sig_a = (w_ea == 5'd0) ? 11'd0 : {1'b1, w_ma};
        w_sig_b = (w_eb == 5'd0) ? 11'd0 : {1'b1, w_mb};
        w_a_big = {w_ea, w_sig_a} >= {w_eb, w_sig_b};
        if (w_a_big) begin
            w_e_l    = w_ea;
            w_e_s    = w_eb;
            w_sig_l  = w_sig_a;
            w_sig_s  = w_sig_b;
            w_sign_l = w_sa;
        end else begin
            w_e_l    = w_eb;
            w_e_s    = w_ea;
            w_sig_l  = w_sig_b;
            w_sig_s  = w_sig_a;
            w_sign_l = w_sb;
        end
        w_diff     = w_e_l - w_e_s;
        w_sig_s_sh = (w_diff >= 5'd12) ? 11'd0 : (w_sig_s >> w_diff);

        w_spec     = 1'b1;
        w_spec_val = QNAN;
        if (w_nan_a || w_nan_b)
            w_spec_val = QNAN;
        else if (w_inf_a && w_inf_b)
            w_spec_val = (w_sa == w_sb) ? r_opa_p0 : QNAN;
        else if (w_inf_a)
            w_spec_val = r_opa_p0;
        else if (w_inf_b)
            w_spec_val = r_opb_p0;
        else
            w_spec = 1'b0;
    end

    always_comb begin
        w_sum = r_sub_p1 ? ({1'b0, r_sig_l_p1} - {1'b0, r_sig_s_p1})
                         : ({1'b0, r_sig_l_p1} + {1'b0, r_sig_s_p1});
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state       <= IDLE;
            r_in_ready    <= 1'b1;
            r_out_valid   <= 1'b0;
            r_acc         <= '0;
            r_opa_p0      <= '0;
            r_opb_p0      <= '0;
            r_sig_l_p1    <= '0;
            r_sig_s_p1    <= '0;
            r_exp_p1      <= '0;
            r_sign_p1     <= 1'b0;
            r_sub_p1      <= 1'b0;
            r_zsign_p1    <= 1'b0;
            r_spec_p1     <= 1'b0;
            r_spec_val_p1 <= '0;
            r_sum_p2      <= '0;
            r_exp_p2      <= '0;
            r_sign_p2     <= 1'b0;
            r_zsign_p2    <= 1'b0;
            r_spec_p2     <= 1'b0;
            r_spec_val_p2 <= '0;
        end else begin
            r_out_valid <= 1'b0;
            case (r_state)
                // capture: accumulator operand is forced to +0 when clear rides along
                IDLE: begin
                    if (in_valid) begin
                        r_opa_p0   <= clear ? 16'h0000 : r_acc;
                        r_opb_p0   <= in_data;
                        r_state    <= ALIGN;
                        r_in_ready <= 1'b0;
                    end else if (clear) begin
                        r_acc <= 16'h0000;
                    end
                end
                // p0 -> p1: operand ordering and significand alignment
                ALIGN: begin
                    r_sig_l_p1    <= w_sig_l;
                    r_sig_s_p1    <= w_sig_s_sh;
                    r_exp_p1      <= w_e_l;
                    r_sign_p1     <= w_sign_l;
                    r_sub_p1      <= w_sa ^ w_sb;
                    r_zsign_p1    <= w_sa & w_sb;
                    r_spec_p1     <= w_spec;
                    r_spec_val_p1 <= w_spec_val;
                    r_state       <= ADD;
                end
                // p1 -> p2: magnitude add/subtract
                ADD: begin
                    r_sum_p2      <= w_sum;
                    r_exp_p2      <= r_exp_p1;
                    r_sign_p2     <= r_sign_p1;
                    r_zsign_p2    <= r_zsign_p1;
                    r_spec_p2     <= r_spec_p1;
                    r_spec_val_p2 <= r_spec_val_p1;
                    r_state       <= NORM;
                end
                // p2 -> accumulator: normalise and publish
                NORM: begin
                    r_acc       <= r_spec_p2 ? r_spec_val_p2
                                             : f_norm_trunc(r_sum_p2, r_exp_p2, r_sign_p2, r_zsign_p2);
                    r_out_valid <= 1'b1;
                    r_in_ready  <= 1'b1;
                    r_state     <= IDLE;
                end
                default: begin
                    r_state    <= IDLE;
                    r_in_ready <= 1'b1;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign acc_out   = r_acc;

endmodule

// File: tb/tb_fp16_accumulator.sv
// Bench for fp16_accumulator: directed corner cases plus randomized addends,
// scored against a magnitude-level binary16 reference model.
module tb_fp16_accumulator;
    logic        CLK = 1'b0;
    logic        RESET;
    logic [15:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic        clear;
    logic [15:0] acc_out;
    logic        out_valid;

    typedef struct {
        logic [15:0] val;
        int          due;
    } exp_t;

    exp_t        sb_q[$];
    int          checks    = 0;
    int          failures  = 0;
    int          edge_cnt  = 0;
    logic [15:0] model_acc = 16'h0000;
    bit          done      = 1'b0;
    logic [15:0] specials [12] = '{16'h0000, 16'h8000, 16'h7C00, 16'hFC00, 16'h7E00, 16'h7D01,
                                   16'h0001, 16'h8123, 16'h7BFF, 16'hFBFF, 16'h3C00, 16'hBC00};

    fp16_accumulator dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .clear     (clear),
        .acc_out   (acc_out),
        .out_valid (out_valid)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) edge_cnt <= edge_cnt + 1;

    // Reference: exact integer magnitudes sig*2^exp, smaller operand truncated
    // to the larger one's grid, result re-encoded by locating its top bit.
    function automatic logic [15:0] ref_add(input logic [15:0] a, input logic [15:0] b);
        int     ea, eb, siga, sigb, el, es, sl, ss, d, al, m, p, e;
        longint ma, mb;
        logic   sgn;
        bit     nan_a, nan_b, inf_a, inf_b;
        ea    = int'(a[14:10]);
        eb    = int'(b[14:10]);
        nan_a = (ea == 31) && (a[9:0] != 10'd0);
        nan_b = (eb == 31) && (b[9:0] != 10'd0);
        inf_a = (ea == 31) && (a[9:0] == 10'd0);
        inf_b = (eb == 31) && (b[9:0] == 10'd0);
        if (nan_a || nan_b) return 16'h7E00;
        if (inf_a && inf_b) return (a[15] == b[15]) ? a : 16'h7E00;
        if (inf_a) return a;
        if (inf_b) return b;
        siga = (ea == 0) ? 0 : 1024 + int'(a[9:0]);
        sigb = (eb == 0) ? 0 : 1024 + int'(b[9:0]);
        ma   = longint'(siga) << ea;
        mb   = longint'(sigb) << eb;
        if (ma >= mb) begin
            el = ea; sl = siga; es = eb; ss = sigb; sgn = a[15];
        end else begin
            el = eb; sl = sigb; es = ea; ss = siga; sgn = b[15];
        end
        d  = el - es;
        al = (d >= 12) ? 0 : (ss >> d);
        m  = (a[15] == b[15]) ? sl + al : sl - al;
        if (m == 0) return {a[15] & b[15], 15'd0};
        p = 0;
        while ((m >> (p + 1)) != 0) p++;
        e = el + p - 10;
        if (e <= 0) return 16'h0000;
        if (e >= 31) return {sgn, 15'h7C00};
        m = (p >= 10) ? (m >> (p - 10)) : (m << (10 - p));
        return {sgn, e[4:0], m[9:0]};
    endfunction

    task automatic chk16(input string name, input logic [15:0] got, input logic [15:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    task automatic chk1(input string name, input logic got, input logic want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s: got %b want %b", name, got, want);
        end
    endtask

    task automatic monitor();
        exp_t item;
        while (!done) begin
            @(negedge CLK);
            if (out_valid === 1'b1) begin
                checks++;
                if (sb_q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_pulse: out_valid=1 acc_out=%h with nothing pending", acc_out);
                end else begin
                    item = sb_q.pop_front();
                    if (edge_cnt != item.due) begin
                        failures++;
                        $display("FAIL latency: pulse after edge %0d want edge %0d", edge_cnt, item.due);
                    end
                    chk16("acc_out", acc_out, item.val);
                end
            end
        end
    endtask

    // Called at a negedge; returns at the negedge where the block is idle again.
    task automatic xfer(input logic [15:0] d, input bit clr, input bit junk);
        int   guard;
        exp_t item;
        guard = 0;
        while (in_ready !== 1'b1 && guard < 20) begin
            @(negedge CLK);
            guard++;
        end
        if (guard >= 20) begin
            checks++;
            failures++;
            $display("FAIL xfer_wait: in_ready=%b want 1", in_ready);
            return;
        end
        in_valid  = 1'b1;
        in_data   = d;
        clear     = clr;
        item.val  = ref_add(clr ? 16'h0000 : model_acc, d);
        item.due  = edge_cnt + 4;
        model_acc = item.val;
        sb_q.push_back(item);
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            chk1("in_ready_busy", in_ready, 1'b0);
            in_valid = junk ? 1'($urandom) : 1'b0;
            in_data  = 16'($urandom);
            clear    = junk ? 1'($urandom) : 1'b0;
        end
        @(negedge CLK);
        chk1("in_ready_idle", in_ready, 1'b1);
        in_valid = 1'b0;
        clear    = 1'b0;
    endtask

    task automatic do_clear();
        clear    = 1'b1;
        in_valid = 1'b0;
        @(negedge CLK);
        clear = 1'b0;
        chk16("clear", acc_out, 16'h0000);
        model_acc = 16'h0000;
    endtask

    initial begin
        int g;
        RESET    = 1'b1;
        in_valid = 1'b0;
        clear    = 1'b0;
        in_data  = 16'h0000;
        fork
            monitor();
        join_none
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        chk16("rst_acc", acc_out, 16'h0000);
        chk1("rst_vld", out_valid, 1'b0);
        chk1("rst_rdy", in_ready, 1'b1);
        RESET = 1'b0;
        @(negedge CLK);
        chk16("post_rst_acc", acc_out, 16'h0000);
        chk1("post_rst_vld", out_valid, 1'b0);
        chk1("post_rst_rdy", in_ready, 1'b1);

        xfer(16'h3C00, 1'b0, 1'b0); chk16("one", acc_out, 16'h3C00);
        xfer(16'h3C00, 1'b0, 1'b0); chk16("two", acc_out, 16'h4000);
        do_clear();
        xfer(16'h7BFF, 1'b0, 1'b0); chk16("max", acc_out, 16'h7BFF);
        xfer(16'h7BFF, 1'b0, 1'b0); chk16("ovf_inf", acc_out, 16'h7C00);
        do_clear();
        xfer(16'h7C00, 1'b0, 1'b0);
        xfer(16'hFC00, 1'b0, 1'b0); chk16("inf_minus_inf", acc_out, 16'h7E00);
        xfer(16'h528F, 1'b0, 1'b0); chk16("nan_sticky", acc_out, 16'h7E00);
        do_clear();
        xfer(16'h3C00, 1'b0, 1'b0);
        xfer(16'hBC00, 1'b0, 1'b0); chk16("cancel", acc_out, 16'h0000);
        do_clear();
        xfer(16'h0001, 1'b0, 1'b0); chk16("subnormal", acc_out, 16'h0000);
        xfer(16'h4000, 1'b0, 1'b0);
        xfer(16'h4200, 1'b1, 1'b0); chk16("clear_xfer", acc_out, 16'h4200);

        // reset lands on the edge that ends ADD: the pending result must vanish
        in_valid = 1'b1;
        in_data  = 16'h3C00;
        @(negedge CLK);
        in_valid = 1'b0;
        @(negedge CLK);
        RESET = 1'b1;
        @(negedge CLK);
        RESET = 1'b0;
        model_acc = 16'h0000;
        repeat (5) @(negedge CLK);
        chk16("abort_acc", acc_out, 16'h0000);
        chk1("abort_rdy", in_ready, 1'b1);

        xfer(16'h3C00, 1'b0, 1'b0);
        RESET    = 1'b1;
        in_valid = 1'b1;
        in_data  = 16'h4400;
        @(negedge CLK);
        RESET    = 1'b0;
        in_valid = 1'b0;
        model_acc = 16'h0000;
        chk1("rst_prio_rdy", in_ready, 1'b1);
        chk16("rst_prio_acc", acc_out, 16'h0000);
        repeat (4) @(negedge CLK);

        for (int n = 0; n < 300; n++) begin
            int          cat;
            logic [15:0] d;
            cat = int'($urandom_range(0, 9));
            if (cat < 4)
                d = 16'($urandom);
            else if (cat < 6)
                d = specials[$urandom_range(0, 11)];
            else if (cat < 8)
                d = {~model_acc[15], model_acc[14:0]} ^ 16'($urandom_range(0, 7));
            else
                d = {1'($urandom), model_acc[14:10] - 5'($urandom_range(0, 12)), 10'($urandom)};
            if ($urandom_range(0, 15) == 0) do_clear();
            xfer(d, $urandom_range(0, 9) == 0, 1'b1);
        end

        g = 0;
        while (sb_q.size() != 0 && g < 50) begin
            @(negedge CLK);
            g++;
        end
        if (sb_q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL drain: %0d results still pending want 0", sb_q.size());
        end
        repeat (4) @(negedge CLK);
        done = 1'b1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
